sa_mul_ctrl: RTL

//  Sequencer and adder stage for the shift-add unsigned multiplier; sits directly upstream of the

---
 rtl/sa_mul_ctrl_pkg.sv | 21 ++
 rtl/sa_mul_ctrl_if.sv | 37 +++
 rtl/sa_adder_carry.sv | 35 +++
 rtl/sa_mul_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/sa_mul_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sa_mul_ctrl_pkg                                                          |
// | Shared width and state encodings for the shift-add multiplier control.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sa_mul_ctrl_pkg;

    localparam int SA_WIDTH = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_EVAL  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } sa_state_t;

endpackage : sa_mul_ctrl_pkg
`default_nettype wire

// File: rtl/sa_mul_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sa_mul_ctrl_if                                                           |
// | Request, shift-register readback and strobe bundle of the sequencer.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sa_mul_ctrl_if
    import sa_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             lsb;
    logic [WIDTH-1:0] qph;
    logic             load_ph;
    logic             load_pl;
    logic             sft;
    logic             carry;
    logic [WIDTH-1:0] dph;
    logic [WIDTH-1:0] dpl;
    logic             busy;
    logic             done;

    // master = sequencer, slave = requester plus the ph/pl registers
    modport master (
        input  start, mcand, mplier, lsb, qph,
        output load_ph, load_pl, sft, carry, dph, dpl, busy, done
    );

    modport slave (
        output start, mcand, mplier, lsb, qph,
        input  load_ph, load_pl, sft, carry, dph, dpl, busy, done
    );
endinterface : sa_mul_ctrl_if
`default_nettype wire

// File: rtl/sa_adder_carry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sa_adder_carry                                                           |
// | WIDTH-bit adder whose carry-out is held until the following shift.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sa_adder_carry #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             clr,
    input  wire logic             i_en,
    input  wire logic             i_clr_c,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_cry
);
    logic [WIDTH:0] w_sum;
    logic           r_cry;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum = w_sum[WIDTH-1:0];
    assign o_cry = r_cry;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_cry <= 1'b0;
        else if (i_clr_c)
            r_cry <= 1'b0;
        else if (i_en)
            r_cry <= w_sum[WIDTH];
    end
endmodule : sa_adder_carry
`default_nettype wire

// File: rtl/sa_mul_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sa_mul_ctrl                                                              |
// | Sequencer/adder for a shift-add unsigned multiplier driving ph and pl.   |
// | Option: SA_MUL_DONE_HOLD_EN makes done a level held until next start.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sa_mul_ctrl
    import sa_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input wire logic       clk,
    input wire logic       clr,
    sa_mul_ctrl_if.master  bus
);
    sa_state_t        r_state;
    sa_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_sum;
    logic             w_cry;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && bus.start;

    sa_adder_carry #(.WIDTH(WIDTH)) u_add (
        .clk     (clk),
        .clr     (clr),
        .i_en    (r_state == S_ADD),
        .i_clr_c ((r_state == S_INIT) || (r_state == S_SHIFT)),
        .i_a     (bus.qph),
        .i_b     (r_mcand),
        .o_sum   (w_sum),
        .o_cry   (w_cry)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mcand  <= bus.mcand;
                r_mplier <= bus.mplier;
            end
            if (r_state == S_INIT)
                r_cnt <= '0;
            else if (r_state == S_SHIFT)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        bus.load_ph = 1'b0;
        bus.load_pl = 1'b0;
        bus.sft     = 1'b0;
        bus.carry   = 1'b0;
        bus.dph     = '0;
        bus.busy    = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_INIT;
            S_INIT: begin
                bus.load_ph = 1'b1;
                bus.load_pl = 1'b1;
                bus.busy    = 1'b1;
                w_next      = S_EVAL;
            end
            S_EVAL: begin
                bus.busy = 1'b1;
                w_next   = bus.lsb ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                bus.load_ph = 1'b1;
                bus.dph     = w_sum;
                bus.busy    = 1'b1;
                w_next      = S_SHIFT;
            end
            S_SHIFT: begin
                // stored adder carry becomes the new ph MSB
                bus.sft   = 1'b1;
                bus.carry = w_cry;
                bus.busy  = 1'b1;
                w_next    = (r_cnt == CNT_W'(WIDTH - 1)) ? S_DONE : S_EVAL;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.dpl = r_mplier;

`ifdef SA_MUL_DONE_HOLD_EN
    logic r_done;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_done <= 1'b0;
        else if (w_next == S_DONE)
            r_done <= 1'b1;
        else if (w_accept)
            r_done <= 1'b0;
    end

    assign bus.done = r_done;
`else
    assign bus.done = (r_state == S_DONE);
`endif
endmodule : sa_mul_ctrl
`default_nettype wire
